// File: rtl/ct_ebiu_lp_ctrl.sv
// EBIU low-power request sequencer: idle detection, csysreq/csysack handshake,
// interconnect clock-gate grant and sticky handshake-timeout flag.
//
// state   | meaning
// RUN     | normal traffic, counting qualifying idle cycles
// REQ_LOW | csysreq low, waiting for csysack low or timeout
// LOWPWR  | EBIU acknowledged low power, clock gating granted
// EXIT    | csysreq high again, waiting for csysack high
module ct_ebiu_lp_ctrl #(
  parameter int IDLE_THRESH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic forever_cpuclk,
  input  logic cpurst,
  input  logic clk_en,
  input  logic lp_en,
  input  logic ebiu_xx_no_op,
  input  logic wake_req,
  input  logic ebiu_pad_csysack,
  input  logic err_clr,
  output logic pad_ebiu_csysreq,
  output logic lp_ctrl_clk_gate_en,
  output logic lp_ctrl_busy,
  output logic lp_ctrl_timeout_err
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REQ_LOW = 2'd1,
    LOWPWR  = 2'd2,
    EXIT    = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_THRESH - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] idle_cnt, idle_nxt;
  logic [7:0] to_cnt, to_nxt;
  logic       err_set;
  logic       qidle;
  logic       req_d, gate_d, busy_d;

  assign qidle = clk_en & lp_en & ebiu_xx_no_op & ~wake_req;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state               <= RUN;
      idle_cnt            <= 8'd0;
      to_cnt              <= 8'd0;
      pad_ebiu_csysreq    <= 1'b1;
      lp_ctrl_clk_gate_en <= 1'b0;
      lp_ctrl_busy        <= 1'b0;
      lp_ctrl_timeout_err <= 1'b0;
    end else begin
      state               <= state_nxt;
      idle_cnt            <= idle_nxt;
      to_cnt              <= to_nxt;
      pad_ebiu_csysreq    <= req_d;
      lp_ctrl_clk_gate_en <= gate_d;
      lp_ctrl_busy        <= busy_d;
      // set beats clear; clear is honoured even while clk_en is low
      if (err_set)
        lp_ctrl_timeout_err <= 1'b1;
      else if (err_clr)
        lp_ctrl_timeout_err <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    to_nxt    = to_cnt;
    err_set   = 1'b0;
    if (clk_en) begin
      case (state)
        RUN: begin
          if (!qidle) begin
            idle_nxt = 8'd0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_nxt = REQ_LOW;
            idle_nxt  = 8'd0;
            to_nxt    = 8'd0;
          end else begin
            idle_nxt = idle_cnt + 8'd1;
          end
        end
        REQ_LOW: begin
          // ack is checked first so it wins over a coincident timeout
          if (!ebiu_pad_csysack) begin
            state_nxt = LOWPWR;
          end else if (to_cnt == TO_LAST) begin
            err_set   = 1'b1;
            state_nxt = EXIT;
          end else begin
            to_nxt = to_cnt + 8'd1;
          end
        end
        LOWPWR: begin
          if (wake_req || !lp_en || !ebiu_xx_no_op)
            state_nxt = EXIT;
        end
        EXIT: begin
          if (ebiu_pad_csysack) begin
            state_nxt = RUN;
            idle_nxt  = 8'd0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    req_d  = !((state_nxt == REQ_LOW) || (state_nxt == LOWPWR));
    gate_d = (state_nxt == LOWPWR);
    busy_d = (state_nxt != RUN);
  end

endmodule

// File: tb/tb_ct_ebiu_lp_ctrl.sv
// Directed bench for ct_ebiu_lp_ctrl with a 1-cycle csysreq->csysack echo model
// that can be forced to hold csysack high.
module tb_ct_ebiu_lp_ctrl;

  logic clk = 1'b0;
  logic cpurst, clk_en, lp_en, no_op, wake_req, csysack, err_clr;
  logic csysreq, gate_en, busy, to_err;
  logic stuck;
  int   n_vec = 0;
  int   n_bad = 0;

  ct_ebiu_lp_ctrl #(.IDLE_THRESH(4), .TIMEOUT(8)) dut (
    .forever_cpuclk      (clk),
    .cpurst              (cpurst),
    .clk_en              (clk_en),
    .lp_en               (lp_en),
    .ebiu_xx_no_op       (no_op),
    .wake_req            (wake_req),
    .ebiu_pad_csysack    (csysack),
    .err_clr             (err_clr),
    .pad_ebiu_csysreq    (csysreq),
    .lp_ctrl_clk_gate_en (gate_en),
    .lp_ctrl_busy        (busy),
    .lp_ctrl_timeout_err (to_err)
  );

  always #5 clk = ~clk;

  // EBIU model: echoes csysreq one clk_en edge later
  always @(posedge clk) begin
    if (stuck)
      csysack <= 1'b1;
    else if (clk_en)
      csysack <= csysreq;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic gate,
                         input logic bsy, input logic err);
    chk({tag, ".csysreq"}, csysreq, req);
    chk({tag, ".gate"}, gate_en, gate);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".err"}, to_err, err);
  endtask

  initial begin
    csysack  = 1'b1;
    stuck    = 1'b0;
    cpurst   = 1'b1;
    clk_en   = 1'b1;
    lp_en    = 1'b0;
    no_op    = 1'b0;
    wake_req = 1'b0;
    err_clr  = 1'b0;
    step(2);
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // entry: qidle from cycle 0
    cpurst = 1'b0;
    lp_en  = 1'b1;
    no_op  = 1'b1;
    step(3);
    chk_out("entry_c3", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("entry_c4", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk("entry_c5.ack", csysack, 1'b0);
    chk("entry_c5.gate", gate_en, 1'b0);
    step(1);
    chk_out("entry_c6", 1'b0, 1'b1, 1'b1, 1'b0);
    step(4);
    chk_out("lowpwr_c10", 1'b0, 1'b1, 1'b1, 1'b0);

    // wake pulse at cycle 10
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    chk_out("wake_c11", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    chk("wake_c12.ack", csysack, 1'b1);
    chk("wake_c12.busy", busy, 1'b1);
    step(1);
    chk_out("wake_c13", 1'b1, 1'b0, 1'b0, 1'b0);

    // idle break at idle_cnt=2
    step(2);
    no_op = 1'b0;
    step(1);
    no_op = 1'b1;
    step(3);
    chk_out("break_3q", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("break_4q", 1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    chk_out("break_lowpwr", 1'b0, 1'b1, 1'b1, 1'b0);

    // lp_en drop forces exit from LOWPWR and then blocks entry
    lp_en = 1'b0;
    step(1);
    chk_out("lpen_exit", 1'b1, 1'b0, 1'b1, 1'b0);
    step(2);
    chk_out("lpen_run", 1'b1, 1'b0, 1'b0, 1'b0);
    step(6);
    chk_out("lpen_block", 1'b1, 1'b0, 1'b0, 1'b0);

    // timeout with csysack stuck high
    stuck = 1'b1;
    lp_en = 1'b1;
    step(4);
    chk_out("to_req", 1'b0, 1'b0, 1'b1, 1'b0);
    step(7);
    chk_out("to_7", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_out("to_8", 1'b1, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_out("to_exit_run", 1'b1, 1'b0, 1'b0, 1'b1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", to_err, 1'b0);
    step(3);
    chk_out("to2_req", 1'b0, 1'b0, 1'b1, 1'b0);
    step(7);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk_out("to2_set_wins", 1'b1, 1'b0, 1'b1, 1'b1);
    step(1);
    chk("to2_run.busy", busy, 1'b0);

    // clk_en freeze mid-count
    step(2);
    clk_en = 1'b0;
    step(5);
    chk_out("freeze_idle", 1'b1, 1'b0, 1'b0, 1'b1);
    clk_en = 1'b1;
    step(1);
    chk("resume_idle3", csysreq, 1'b1);
    step(1);
    chk_out("resume_req", 1'b0, 1'b0, 1'b1, 1'b1);

    // clk_en freeze in REQ_LOW; err_clr works while frozen
    step(3);
    clk_en = 1'b0;
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("clr_frozen", to_err, 1'b0);
    step(2);
    chk_out("freeze_reqlow", 1'b0, 1'b0, 1'b1, 1'b0);
    clk_en = 1'b1;
    step(4);
    chk_out("resume_to7", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_out("resume_to8", 1'b1, 1'b0, 1'b1, 1'b1);

    // back to LOWPWR, then reset there with clk_en low
    stuck = 1'b0;
    step(1);
    chk("exit_run.busy", busy, 1'b0);
    step(6);
    chk_out("pre_rst_lowpwr", 1'b0, 1'b1, 1'b1, 1'b1);
    cpurst = 1'b1;
    clk_en = 1'b0;
    step(1);
    cpurst = 1'b0;
    clk_en = 1'b1;
    chk_out("rst_lowpwr", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
